// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, PC increment and default datapath widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {address, instruction} pairs for decode.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // clear wins over a same-cycle push/pop so a flush always leaves the queue empty
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives pcreg, issues one outstanding imem read at a time
// and queues fetched words for decode.
module ifetch_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_ena,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int W     = ADDR_W + DATA_W;

  // Handshakes: imem grant fires when imem_req & imem_gnt; a response is accepted when
  // imem_rvalid is seen in WAIT/FLUSH; decode takes the head when inst_valid & inst_ready.
  fetch_state_t     state;
  logic [ADDR_W-1:0] grant_addr;

  logic             gnt_fire;
  logic             push;
  logic             pop;
  logic             space;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic             full;
  logic             empty;
  logic [W-1:0]     head;

  assign imem_req  = (state == FS_REQ) & ~rst;
  assign imem_addr = imem_req ? pc : '0;
  assign gnt_fire  = imem_req & imem_gnt;
  assign pc_ena    = ~rst & (redirect | gnt_fire);

  always_comb begin
    pc_next = '0;
    if (pc_ena) pc_next = redirect ? redirect_pc : pc + ADDR_W'(PC_INC);
  end

  assign pop         = inst_valid & inst_ready;
  assign push        = (state == FS_WAIT) & imem_rvalid & ~redirect & (~full | pop);
  assign space       = (count < CNT_W'(DEPTH));
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  assign inst_valid = ~empty;
  assign inst       = empty ? '0 : head[DATA_W-1:0];
  assign inst_pc    = empty ? '0 : head[W-1:DATA_W];

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({grant_addr, imem_rdata}),
    .pop       (pop),
    .clear     (redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FS_IDLE;
      grant_addr <= '0;
    end else begin
      if (gnt_fire) grant_addr <= pc;
      unique case (state)
        FS_IDLE: begin
          if (redirect || space) state <= FS_REQ;
        end
        FS_REQ: begin
          // a grant in the redirect cycle leaves a stale response in flight
          if (gnt_fire) state <= redirect ? FS_FLUSH : FS_WAIT;
        end
        FS_WAIT: begin
          if (redirect) state <= imem_rvalid ? FS_REQ : FS_FLUSH;
          else if (imem_rvalid) state <= (count_after < CNT_W'(DEPTH)) ? FS_REQ : FS_IDLE;
        end
        FS_FLUSH: begin
          // the stale response retires here even if another redirect lands on it
          if (imem_rvalid) state <= FS_REQ;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule
